// File: rtl/arbiter_router_pkg.sv
// Shared definitions for the round-robin packet arbiter.
//   arb_state_e     : arbiter FSM states (idle / locked on a packet)
//   TimeoutCntWidth : width of the optional lock-stall counter
//   hdr_len()       : extracts the beat-count field from a header beat
package arbiter_router_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  localparam int unsigned TimeoutCntWidth = 16;
  localparam int unsigned HdrMaxWidth     = 64;

  // Returns the low len_nbits of a header beat; the caller narrows the result.
  function automatic logic [HdrMaxWidth-1:0] hdr_len(input logic [HdrMaxWidth-1:0] msg,
                                                     input int unsigned len_nbits);
    logic [HdrMaxWidth-1:0] mask;
    mask = (64'd1 << len_nbits) - 64'd1;
    return msg & mask;
  endfunction

endpackage

// File: rtl/arbiter_router_rr_picker.sv
// Combinational rotating-priority encoder.
// Scans val starting at rr_ptr and wrapping modulo NINPUTS; returns the first set index.
// Ports:
//   val       : per-requester valid vector
//   rr_ptr    : highest-priority index this cycle
//   grant     : index of the first valid requester at or after rr_ptr
//   any_valid : at least one requester is valid
module arbiter_router_rr_picker
  import arbiter_router_pkg::*;
#(
  parameter int unsigned NINPUTS    = 4,
  parameter int unsigned ADDR_NBITS = $clog2(NINPUTS)
) (
  input  logic [NINPUTS-1:0]    val,
  input  logic [ADDR_NBITS-1:0] rr_ptr,
  output logic [ADDR_NBITS-1:0] grant,
  output logic                  any_valid
);

  // cand[k] is the index examined at priority position k.
  logic [ADDR_NBITS-1:0] cand [NINPUTS];

  for (genvar g = 0; g < NINPUTS; g++) begin : g_cand
    assign cand[g] = ADDR_NBITS'((32'(rr_ptr) + 32'(g)) % NINPUTS);
  end

  assign any_valid = |val;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant = rr_ptr;
    for (int i = int'(NINPUTS) - 1; i >= 0; i--) begin
      if (val[cand[i]]) begin
        grant = cand[i];
      end
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin, packet-aware arbiter merging NINPUTS val/rdy streams into one.
// The header beat's low LEN_NBITS carry (beats - 1); the grant stays locked until that
// many beats have passed, then the rotation pointer advances past the granted input.
// Output goes through a single register stage tagged with the source address and a
// last-beat flag.
// Optional feature macro: ARBITER_ROUTER_LOCK_TIMEOUT_EN (abort a lock whose source
// stalls for TIMEOUT_CYCLES cycles and raise sticky err_timeout).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   istream_val/rdy   : per-input handshake (unpacked arrays)
//   istream_msg       : per-input data
//   ostream_val/rdy   : output handshake (val registered)
//   ostream_msg       : {source address, data}
//   ostream_last      : final beat of a packet
//   busy              : arbiter is locked on a packet
//   err_timeout       : sticky lock-timeout flag (0 when feature disabled)
module rr_packet_arbiter
  import arbiter_router_pkg::*;
#(
  parameter int unsigned NBITS          = 32,
  parameter int unsigned NINPUTS        = 4,
  parameter int unsigned ADDR_NBITS     = $clog2(NINPUTS),
  parameter int unsigned LEN_NBITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        istream_val [NINPUTS],
  output logic                        istream_rdy [NINPUTS],
  input  logic [NBITS-1:0]            istream_msg [NINPUTS],
  output logic                        ostream_val,
  input  logic                        ostream_rdy,
  output logic [ADDR_NBITS+NBITS-1:0] ostream_msg,
  output logic                        ostream_last,
  output logic                        busy,
  output logic                        err_timeout
);

  arb_state_e                  state_q, state_d;
  logic [ADDR_NBITS-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_NBITS-1:0]       grant_q, grant_d;
  logic [LEN_NBITS-1:0]        remaining_q, remaining_d;
  logic                        out_full_q;
  logic [ADDR_NBITS+NBITS-1:0] out_msg_q;
  logic                        out_last_q;

  logic [NINPUTS-1:0]    val_vec;
  logic [ADDR_NBITS-1:0] pick_grant;
  logic                  pick_any;
  logic [ADDR_NBITS-1:0] sel;
  logic                  sel_active;
  logic                  sel_val;
  logic [NBITS-1:0]      sel_msg;
  logic                  in_rdy;
  logic                  accept;
  logic                  beat_last;
  logic [LEN_NBITS-1:0]  hdr_field;
  logic                  tmo_hit;

  function automatic logic [ADDR_NBITS-1:0] ptr_inc(input logic [ADDR_NBITS-1:0] p);
    return (p == ADDR_NBITS'(NINPUTS - 1)) ? '0 : p + ADDR_NBITS'(1);
  endfunction

  for (genvar g = 0; g < NINPUTS; g++) begin : g_val
    assign val_vec[g] = istream_val[g];
  end

  arbiter_router_rr_picker #(
    .NINPUTS    (NINPUTS),
    .ADDR_NBITS (ADDR_NBITS)
  ) u_picker (
    .val       (val_vec),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .any_valid (pick_any)
  );

  // The locked input owns the port whether or not it is presenting a beat.
  always_comb begin
    sel        = (state_q == StLocked) ? grant_q : pick_grant;
    sel_active = (state_q == StLocked) || pick_any;
    sel_val    = val_vec[sel];
    sel_msg    = istream_msg[sel];
    in_rdy     = !out_full_q || ostream_rdy;
    accept     = !reset && sel_active && sel_val && in_rdy;
    hdr_field  = LEN_NBITS'(hdr_len(HdrMaxWidth'(sel_msg), LEN_NBITS));
    beat_last  = (state_q == StIdle) ? (hdr_field == '0) : (remaining_q == LEN_NBITS'(1));
  end

  for (genvar g = 0; g < NINPUTS; g++) begin : g_rdy
    assign istream_rdy[g] = !reset && sel_active && in_rdy && (sel == ADDR_NBITS'(g));
  end

`ifdef ARBITER_ROUTER_LOCK_TIMEOUT_EN
  logic [TimeoutCntWidth-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                       err_q, err_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive stall cycle of the locked source.
  assign tmo_hit = (state_q == StLocked) && !sel_val &&
                   (tmo_cnt_q == TimeoutCntWidth'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if ((state_q != StLocked) || accept || tmo_hit) begin
      tmo_cnt_d = '0;
    end else if (!sel_val) begin
      tmo_cnt_d = tmo_cnt_q + TimeoutCntWidth'(1);
    end
    if (tmo_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_field == '0) begin
            rr_ptr_d = ptr_inc(sel);
          end else begin
            state_d     = StLocked;
            grant_d     = sel;
            remaining_d = hdr_field;
          end
        end
      end
      StLocked: begin
        if (accept) begin
          remaining_d = remaining_q - LEN_NBITS'(1);
          if (remaining_q == LEN_NBITS'(1)) begin
            state_d  = StIdle;
            rr_ptr_d = ptr_inc(grant_q);
          end
        end else if (tmo_hit) begin
          // Abandon the packet without forging a closing beat.
          state_d     = StIdle;
          rr_ptr_d    = ptr_inc(grant_q);
          remaining_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      remaining_q <= '0;
      out_full_q  <= 1'b0;
      out_msg_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      remaining_q <= remaining_d;
      if (accept) begin
        out_full_q <= 1'b1;
        out_msg_q  <= {sel, sel_msg};
        out_last_q <= beat_last;
      end else if (ostream_rdy) begin
        out_full_q <= 1'b0;
        out_last_q <= 1'b0;
      end
    end
  end

  assign ostream_val  = out_full_q;
  assign ostream_msg  = out_msg_q;
  assign ostream_last = out_last_q;
  assign busy         = (state_q == StLocked);

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench for rr_packet_arbiter (NINPUTS=4, NBITS=32, LEN_NBITS=4,
// TIMEOUT_CYCLES=8). Per-input source queues feed the DUT; expected output beats
// are pushed when stimulus is issued and a monitor pops/compares on each handshake.
module tb_rr_packet_arbiter;

  localparam int unsigned NBITS      = 32;
  localparam int unsigned NINPUTS    = 4;
  localparam int unsigned ADDR_NBITS = 2;
  localparam int unsigned LEN_NBITS  = 4;
  localparam int unsigned OW         = ADDR_NBITS + NBITS + 1;

  typedef logic [OW-1:0] beat_t;

  logic                        clk;
  logic                        reset;
  logic                        istream_val [NINPUTS];
  logic                        istream_rdy [NINPUTS];
  logic [NBITS-1:0]            istream_msg [NINPUTS];
  logic                        ostream_val;
  logic                        ostream_rdy;
  logic [ADDR_NBITS+NBITS-1:0] ostream_msg;
  logic                        ostream_last;
  logic                        busy;
  logic                        err_timeout;

  beat_t            exp_q [$];
  logic [NBITS-1:0] src_q [NINPUTS][$];
  bit               gap [NINPUTS];
  bit               drv_fire [NINPUTS];
  int               n_cmp;
  int               n_fail;

  rr_packet_arbiter #(
    .NBITS          (NBITS),
    .NINPUTS        (NINPUTS),
    .ADDR_NBITS     (ADDR_NBITS),
    .LEN_NBITS      (LEN_NBITS),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .istream_val  (istream_val),
    .istream_rdy  (istream_rdy),
    .istream_msg  (istream_msg),
    .ostream_val  (ostream_val),
    .ostream_rdy  (ostream_rdy),
    .ostream_msg  (ostream_msg),
    .ostream_last (ostream_last),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [NBITS-1:0] mk(input logic [27:0] tag, input logic [3:0] len);
    return {tag, len};
  endfunction

  function automatic void exp_beat(input int unsigned addr, input logic [NBITS-1:0] data,
                                   input logic last);
    exp_q.push_back({last, ADDR_NBITS'(addr), data});
  endfunction

  function automatic logic rdy_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NINPUTS); i++) r = r | istream_rdy[i];
    return r;
  endfunction

  function automatic bit src_busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < int'(NINPUTS); i++) if (src_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || src_busy()) && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Source driver: present queue heads at negedge, sample handshake just before posedge.
  initial begin
    for (int i = 0; i < int'(NINPUTS); i++) begin
      istream_val[i] = 1'b0;
      istream_msg[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NINPUTS); i++) begin
        istream_val[i] = (src_q[i].size() != 0) && !gap[i];
        istream_msg[i] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      end
      #4;
      for (int i = 0; i < int'(NINPUTS); i++) begin
        drv_fire[i] = istream_val[i] && istream_rdy[i] && !reset;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(NINPUTS); i++) begin
        if (drv_fire[i]) void'(src_q[i].pop_front());
      end
    end
  end

  // Output monitor.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && ostream_val && ostream_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h, expected no beat",
                   {ostream_last, ostream_msg});
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 64'({ostream_last, ostream_msg}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    ostream_rdy = 1'b1;
    for (int i = 0; i < int'(NINPUTS); i++) gap[i] = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    #2;
    check("reset_rdy", 64'(rdy_any()), 64'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #2;
    check("reset_oval", 64'(ostream_val), 64'(0));
    check("reset_omsg", 64'(ostream_msg), 64'(0));
    check("reset_olast", 64'(ostream_last), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_err", 64'(err_timeout), 64'(0));
    @(posedge clk);
    #2;

    // T1: all inputs, single-beat packets -> 0,1,2,3,0,1,2,3 back to back.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < int'(NINPUTS); i++) begin
        src_q[i].push_back(mk(28'(32'h100_0000 + 32'(i * 16 + k)), 4'd0));
      end
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < int'(NINPUTS); i++) begin
        exp_beat(i, mk(28'(32'h100_0000 + 32'(i * 16 + k)), 4'd0), 1'b1);
      end
    end
    @(posedge clk);
    #2;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #2;
      check($sformatf("t1_no_bubble_%0d", c), 64'(ostream_val), 64'(1));
      @(posedge clk);
      #2;
    end
    wait_drain("t1");

    // T2: move pointer to 2, then input 2 sends 4 beats while input 0 waits.
    src_q[1].push_back(mk(28'h200_0001, 4'd0));
    exp_beat(1, mk(28'h200_0001, 4'd0), 1'b1);
    wait_drain("t2a");
    src_q[0].push_back(mk(28'h200_0100, 4'd0));
    src_q[2].push_back(mk(28'h200_0200, 4'd3));
    src_q[2].push_back(32'h2000_021F);
    src_q[2].push_back(32'h2000_022E);
    src_q[2].push_back(32'h2000_023D);
    exp_beat(2, mk(28'h200_0200, 4'd3), 1'b0);
    exp_beat(2, 32'h2000_021F, 1'b0);
    exp_beat(2, 32'h2000_022E, 1'b0);
    exp_beat(2, 32'h2000_023D, 1'b1);
    exp_beat(0, mk(28'h200_0100, 4'd0), 1'b1);
    @(posedge clk);
    #2;
    @(negedge clk);
    #2;
    check("t2_busy", 64'(busy), 64'(1));
    check("t2_rdy0_masked", 64'(istream_rdy[0]), 64'(0));
    wait_drain("t2b");

    // T3: pointer at 1; input 1 locks, stalls 5 cycles while 0 and 3 wait.
    src_q[1].push_back(mk(28'h300_0100, 4'd3));
    src_q[1].push_back(32'h3000_0111);
    src_q[1].push_back(32'h3000_0122);
    src_q[1].push_back(32'h3000_0133);
    src_q[0].push_back(mk(28'h300_0000, 4'd0));
    src_q[3].push_back(mk(28'h300_0300, 4'd0));
    exp_beat(1, mk(28'h300_0100, 4'd3), 1'b0);
    exp_beat(1, 32'h3000_0111, 1'b0);
    exp_beat(1, 32'h3000_0122, 1'b0);
    exp_beat(1, 32'h3000_0133, 1'b1);
    exp_beat(3, mk(28'h300_0300, 4'd0), 1'b1);
    exp_beat(0, mk(28'h300_0000, 4'd0), 1'b1);
    @(posedge clk);
    #2;
    gap[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #2;
      check($sformatf("t3_rdy0_%0d", c), 64'(istream_rdy[0]), 64'(0));
      check($sformatf("t3_rdy3_%0d", c), 64'(istream_rdy[3]), 64'(0));
      check($sformatf("t3_busy_%0d", c), 64'(busy), 64'(1));
      if (c > 0) check($sformatf("t3_no_beat_%0d", c), 64'(ostream_val), 64'(0));
      @(posedge clk);
      #2;
    end
    gap[1] = 1'b0;
    wait_drain("t3");

    // T4: pointer at 1; output back-pressure for 3 cycles with register full.
    src_q[2].push_back(mk(28'h400_0200, 4'd0));
    src_q[3].push_back(mk(28'h400_0300, 4'd0));
    exp_beat(2, mk(28'h400_0200, 4'd0), 1'b1);
    exp_beat(3, mk(28'h400_0300, 4'd0), 1'b1);
    ostream_rdy = 1'b0;
    @(posedge clk);
    #2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      check($sformatf("t4_rdy_low_%0d", c), 64'(rdy_any()), 64'(0));
      check($sformatf("t4_oval_%0d", c), 64'(ostream_val), 64'(1));
      check($sformatf("t4_omsg_%0d", c), 64'(ostream_msg),
            64'({2'd2, mk(28'h400_0200, 4'd0)}));
      @(posedge clk);
      #2;
    end
    ostream_rdy = 1'b1;
    wait_drain("t4");

    // T5: pointer at 0; reset while beat 2 of input 3's packet is accepted.
    src_q[3].push_back(mk(28'h500_0300, 4'd3));
    src_q[3].push_back(32'h5000_0311);
    src_q[3].push_back(32'h5000_0322);
    src_q[3].push_back(32'h5000_0333);
    exp_beat(3, mk(28'h500_0300, 4'd3), 1'b0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b1;
    src_q[3].delete();
    src_q[0].push_back(mk(28'h500_0000, 4'd0));
    src_q[2].push_back(mk(28'h500_0200, 4'd0));
    @(negedge clk);
    #2;
    check("t5_rdy_in_reset", 64'(rdy_any()), 64'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    check("t5_oval", 64'(ostream_val), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_olast", 64'(ostream_last), 64'(0));
    exp_beat(0, mk(28'h500_0000, 4'd0), 1'b1);
    exp_beat(2, mk(28'h500_0200, 4'd0), 1'b1);
    wait_drain("t5");

`ifdef ARBITER_ROUTER_LOCK_TIMEOUT_EN
    // T6: pointer at 3; input 1 locks then stalls; abort after 8 cycles, input 2 next.
    begin
      int c;
      src_q[1].push_back(mk(28'h600_0100, 4'd3));
      src_q[1].push_back(32'h6000_0111);
      src_q[1].push_back(32'h6000_0122);
      src_q[1].push_back(32'h6000_0133);
      exp_beat(1, mk(28'h600_0100, 4'd3), 1'b0);
      @(posedge clk);
      #2;
      gap[1] = 1'b1;
      src_q[2].push_back(mk(28'h600_0200, 4'd0));
      exp_beat(2, mk(28'h600_0200, 4'd0), 1'b1);
      c = 0;
      while (!err_timeout && c < 30) begin
        @(posedge clk);
        #2;
        c++;
      end
      check("t6_err", 64'(err_timeout), 64'(1));
      check("t6_stall_cycles", 64'(c), 64'(8));
      check("t6_busy", 64'(busy), 64'(0));
      src_q[1].delete();
      gap[1] = 1'b0;
      wait_drain("t6");
      check("t6_err_sticky", 64'(err_timeout), 64'(1));
    end
`else
    check("err_tied_low", 64'(err_timeout), 64'(0));
`endif

    repeat (3) @(posedge clk);
    #2;
    check("final_idle", 64'(busy), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
